stream_sort_arbiter: RTL

- Shares one stream_bubble_sort instance between two AXI-stream requesters, one whole packet at a time.
- Grants a requester round-robin and forwards its packet into the sorter. It then waits for the sorted packet to be fully ejected and returns it on a single output stream, tagged with the requester index.
- Sits directly in front of and behind the sorter. It also enforces the sorter's maximum packet length.

---
 rtl/stream_sort_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/stream_sort_arbiter.sv
// Two-requester, packet-granular round-robin front end for a shared stream sorter.
// Forwards one granted packet into the sorter, then returns its sorted result tagged with the requester index.
module stream_sort_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  src0_tvalid,
    output logic                  src0_tready,
    input  logic [DATA_WIDTH-1:0] src0_tdata,
    input  logic                  src0_tlast,

    input  logic                  src1_tvalid,
    output logic                  src1_tready,
    input  logic [DATA_WIDTH-1:0] src1_tdata,
    input  logic                  src1_tlast,

    output logic                  sort_src_tvalid,
    input  logic                  sort_src_tready,
    output logic [DATA_WIDTH-1:0] sort_src_tdata,
    output logic                  sort_src_tlast,

    input  logic                  sort_dest_tvalid,
    output logic                  sort_dest_tready,
    input  logic [DATA_WIDTH-1:0] sort_dest_tdata,
    input  logic                  sort_dest_tlast,

    output logic                  dest_tvalid,
    input  logic                  dest_tready,
    output logic [DATA_WIDTH-1:0] dest_tdata,
    output logic                  dest_tlast,
    output logic                  dest_tid,

    output logic                  busy,
    output logic [1:0]            trunc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } sm_t;

    // Index of the final beat the sorter FIFO can hold.
    localparam logic [ADDR_WIDTH:0] BEAT_LAST = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);
    localparam logic [ADDR_WIDTH:0] BEAT_ONE  = (ADDR_WIDTH+1)'(1);

    sm_t                 sm_reg, sm_next;
    logic                grant_reg, grant_next;
    logic                last_grant_reg, last_grant_next;
    logic [ADDR_WIDTH:0] beat_cnt_reg, beat_cnt_next;
    logic [1:0]          trunc_reg, trunc_next;

    logic [1:0]            req_valid;
    logic [1:0]            req_last;
    logic [1:0]            req_ready;
    logic [DATA_WIDTH-1:0] req_data [2];

    logic                  in_fill;
    logic                  in_drain;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  forced_last;
    logic                  accept_beat;
    logic                  dest_done;

    assign req_valid   = {src1_tvalid, src0_tvalid};
    assign req_last    = {src1_tlast, src0_tlast};
    assign req_data[0] = src0_tdata;
    assign req_data[1] = src1_tdata;

    assign in_fill  = (sm_reg == FILL);
    assign in_drain = (sm_reg == DRAIN);

    // Ready is a function of state and the sorter only, never of any requester's valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req_ready
            assign req_ready[gi] = in_fill && (grant_reg == 1'(gi)) && sort_src_tready;
        end
    endgenerate

    assign src0_tready = req_ready[0];
    assign src1_tready = req_ready[1];

    assign sel_valid   = req_valid[grant_reg];
    assign sel_last    = req_last[grant_reg];
    assign forced_last = (beat_cnt_reg == BEAT_LAST);

    assign sort_src_tvalid = in_fill && sel_valid;
    assign sort_src_tdata  = req_data[grant_reg];
    assign sort_src_tlast  = in_fill && (sel_last || forced_last);
    assign accept_beat     = sort_src_tvalid && sort_src_tready;

    assign sort_dest_tready = in_drain && dest_tready;
    assign dest_tvalid      = in_drain && sort_dest_tvalid;
    assign dest_tdata       = sort_dest_tdata;
    assign dest_tlast       = sort_dest_tlast;
    assign dest_tid         = in_drain && grant_reg;
    assign dest_done        = dest_tvalid && dest_tready && dest_tlast;

    assign busy  = (sm_reg != IDLE);
    assign trunc = trunc_reg;

    always_comb begin
        sm_next         = sm_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        trunc_next      = trunc_reg;

        case (sm_reg)
            IDLE: begin
                if (|req_valid) begin
                    // On a tie the requester that was not served last goes next.
                    grant_next    = (&req_valid) ? ~last_grant_reg : req_valid[1];
                    beat_cnt_next = '0;
                    sm_next       = FILL;
                end
            end
            FILL: begin
                if (accept_beat) begin
                    beat_cnt_next = beat_cnt_reg + BEAT_ONE;
                    if (sort_src_tlast) begin
                        sm_next = DRAIN;
                        if (!sel_last) begin
                            trunc_next[grant_reg] = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (dest_done) begin
                    last_grant_next = grant_reg;
                    sm_next         = IDLE;
                end
            end
            default: sm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sm_reg         <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            beat_cnt_reg   <= '0;
            trunc_reg      <= 2'b00;
        end else begin
            sm_reg         <= sm_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
            trunc_reg      <= trunc_next;
        end
    end

endmodule
